// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the data-memory responder.
//   - RW_* : funct3 access-type codes presented on rw_type
//   - state_t : responder FSM state encoding (ST_IDLE, ST_SPLIT)
//   - lane_mask() : byte lanes touched by an access, spread over two words
//   - type_legal() : recognises the five supported access types
package mem_pkg;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_H  = 3'b001;
    localparam logic [2:0] RW_W  = 3'b010;
    localparam logic [2:0] RW_BU = 3'b100;
    localparam logic [2:0] RW_HU = 3'b101;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_t;

    // Bits [3:0] are the lanes of word w, bits [7:4] the lanes of word w+1.
    // Any bit set in [7:4] means the access crosses a word boundary.
    function automatic logic [7:0] lane_mask(input logic [2:0] rw_type, input logic [1:0] off);
        logic [7:0] m;
        case (rw_type)
            RW_B, RW_BU: m = 8'b0000_0001;
            RW_H, RW_HU: m = 8'b0000_0011;
            RW_W:        m = 8'b0000_1111;
            default:     m = 8'b0000_0000;
        endcase
        return m << off;
    endfunction

    function automatic logic type_legal(input logic [2:0] rw_type);
        logic ok;
        case (rw_type)
            RW_B, RW_H, RW_W, RW_BU, RW_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/byte_ram.sv
module byte_ram #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  input  logic                  re,
  output logic [31:0]           rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: load/store responder for the single-cycle RISC-V core.
//   clk, rst        : clock, synchronous active-high reset
//   rd_en, wr_en    : load / store request (accepted in the cycle presented)
//   ram_addr        : byte address, bits [ADDR_WIDTH+1:2] select the word
//   rw_type         : funct3 access type (B, H, W, BU, HU)
//   wr_mem_data     : right-justified store data
//   rd_mem_data     : extended load data, non-zero only while rd_valid
//   rd_valid        : one-cycle pulse with load data
//   stall           : core must hold its request (first beat of a split access)
//   access_err      : one-cycle pulse for an illegal request
// Build option MISALIGN_SPLIT_EN: when defined, word-crossing accesses are
// split into two beats by the IDLE/SPLIT FSM; otherwise they are illegal.
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] ram_addr,
    input  logic [2:0]  rw_type,
    input  logic [31:0] wr_mem_data,
    output logic [31:0] rd_mem_data,
    output logic        rd_valid,
    output logic        stall,
    output logic        access_err
);

`ifdef MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [2:0] t);
        logic [31:0] r;
        case (t)
            RW_B:    r = {{24{d[7]}}, d[7:0]};
            RW_BU:   r = {24'h0, d[7:0]};
            RW_H:    r = {{16{d[15]}}, d[15:0]};
            RW_HU:   r = {16'h0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t                r_state;
    logic                  r_rd_valid;
    logic                  r_err;
    logic                  r_zero;      // result forced to zero (illegal read)
    logic                  r_merge;     // result spans the captured beat-0 word
    logic [1:0]            r_out_off;
    logic [2:0]            r_out_type;
    logic [ADDR_WIDTH-1:0] r_word1;
    logic [3:0]            r_mask_hi;
    logic [31:0]           r_wdata_hi;
    logic                  r_is_wr;
    logic [31:0]           r_word0;

    logic [1:0]            w_off;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [7:0]            w_mask8;
    logic [63:0]           w_wdata64;
    logic                  w_req;
    logic                  w_mis;
    logic                  w_bad;
    logic                  w_idle;
    logic                  w_accept;
    logic                  w_good;
    logic                  w_split_go;
    logic                  w_beat1;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [3:0]            w_ram_we;
    logic [31:0]           w_ram_wdata;
    logic                  w_ram_re;
    logic [31:0]           w_ram_rdata;
    logic [31:0]           w_lo;
    logic [31:0]           w_shift;
    logic                  w_unused;

    assign w_off      = ram_addr[1:0];
    assign w_word     = ram_addr[ADDR_WIDTH+1:2];
    assign w_unused   = ^ram_addr[31:ADDR_WIDTH+2];  // high address bits alias
    assign w_mask8    = lane_mask(rw_type, w_off);
    assign w_wdata64  = {32'h0, wr_mem_data} << {w_off, 3'b000};
    assign w_req      = rd_en | wr_en;
    assign w_mis      = |w_mask8[7:4];
    assign w_bad      = !type_legal(rw_type) || (rd_en && wr_en) || (w_mis && !SPLIT_EN);
    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = !rst && w_idle && w_req;
    assign w_good     = w_accept && !w_bad;
    assign w_split_go = w_good && w_mis;
    // A reset arriving during SPLIT drops the second beat.
    assign w_beat1    = !rst && (r_state == ST_SPLIT);

    assign stall      = w_split_go;

    // RAM port: second beat of a split access has priority; in SPLIT no new
    // request can be accepted, so the two sources never collide.
    always_comb begin
        w_ram_addr  = w_word;
        w_ram_we    = 4'b0000;
        w_ram_wdata = w_wdata64[31:0];
        w_ram_re    = 1'b0;
        if (w_beat1) begin
            w_ram_addr  = r_word1;
            w_ram_we    = r_is_wr ? r_mask_hi : 4'b0000;
            w_ram_wdata = r_wdata_hi;
            w_ram_re    = !r_is_wr;
        end else if (w_good) begin
            w_ram_we = wr_en ? w_mask8[3:0] : 4'b0000;
            w_ram_re = rd_en;
        end
    end

    byte_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .addr  (w_ram_addr),
        .we    (w_ram_we),
        .wdata (w_ram_wdata),
        .re    (w_ram_re),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        // Datapath holding registers, not reset.
        if (w_split_go) begin
            r_word1    <= w_word + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            r_mask_hi  <= w_mask8[7:4];
            r_wdata_hi <= w_wdata64[63:32];
            r_is_wr    <= wr_en;
        end
        if (r_state == ST_SPLIT) r_word0 <= w_ram_rdata;
        if (w_accept) begin
            r_out_off  <= w_off;
            r_out_type <= rw_type;
        end

        // Control.
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_zero     <= 1'b0;
            r_merge    <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_err   <= w_bad;
                        r_zero  <= w_bad;
                        r_merge <= 1'b0;
                        if (w_bad)      r_rd_valid <= rd_en;
                        else if (w_mis) r_state    <= ST_SPLIT;
                        else            r_rd_valid <= rd_en;
                    end
                end
                ST_SPLIT: begin
                    r_state    <= ST_IDLE;
                    r_rd_valid <= !r_is_wr;
                    r_zero     <= 1'b0;
                    r_merge    <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Result alignment: for a split read the beat-0 word was captured and the
    // RAM now presents word w+1; otherwise the RAM word alone is used.
    assign w_lo    = r_merge ? r_word0 : w_ram_rdata;
    assign w_shift = 32'({w_ram_rdata, w_lo} >> {r_out_off, 3'b000});

    assign rd_valid    = r_rd_valid;
    assign access_err  = r_err;
    assign rd_mem_data = (r_rd_valid && !r_zero) ? load_extend(w_shift, r_out_type) : 32'h0;

endmodule
